seg_disp_ctrl: RTL and testbench

Scan controller for the board's 8-digit seven-segment display, driven by the single-cycle CPU top level. It accepts 32-bit display words from the CPU side over a valid/ready handshake and holds each word in a shadow register. New words are committed only at frame boundaries, so the display never tears. It time-multiplexes the eight hex digits onto `o_seg`/`o_sel` with a programmable prescaler.

---
 rtl/seg_disp_pkg.sv | 18 +
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg_disp_ctrl.sv | 126 ++++++++++++
 tb/tb_seg_disp_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the 8-digit seven-segment scan controller.
package seg_disp_pkg;

  typedef enum logic {
    SD_IDLE = 1'b0,
    SD_SCAN = 1'b1
  } sd_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         DIGITS    = 8;

  // Active-low g..a patterns with dp (bit7) held off, indexed by hex value.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg_disp_ctrl.sv
// Tear-free scan controller for an 8-digit seven-segment display.
// Optional leading-zero blanking is enabled with `define SEG_LZ_BLANK_EN.
module seg_disp_ctrl
  import seg_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_data,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel,
  output logic        frame_done,
  output logic        dbg_scan_o
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [2:0]  IDX_LAST = 3'(DIGITS - 1);

  sd_state_e   state_q, state_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] disp_q, disp_d;
  logic [7:0]  seg_q, seg_d;
  logic [7:0]  sel_q, sel_d;
  logic        wrap_q, wrap_d;
  logic        fdone_q, fdone_d;

  logic        tick;
  logic        wrap;
  logic        xfer;
  logic        commit;
  logic [4:0]  nib_base;
  logic [7:0]  dec_seg;
  logic        lz_blank;

  // Handshake: a word transfers on any edge where upd_valid && upd_ready;
  // upd_ready is simply ~pend, so a commit and a transfer never coincide.
  assign upd_ready  = ~pend_q;
  assign o_seg      = seg_q;
  assign o_sel      = sel_q;
  assign frame_done = fdone_q;
  assign dbg_scan_o = (state_q == SD_SCAN);

  assign tick     = (div_cnt_q == DIV_LAST);
  assign wrap     = tick && (idx_q == IDX_LAST);
  assign xfer     = upd_valid && !pend_q;
  assign commit   = wrap && pend_q;
  assign nib_base = {idx_q, 2'b00};

  seg7_hex_decode u_dec (
    .nib_i (disp_q[nib_base +: 4]),
    .seg_o (dec_seg)
  );

`ifdef SEG_LZ_BLANK_EN
  assign lz_blank = (idx_q != 3'd0) && ((disp_q >> nib_base) == 32'd0);
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
    idx_d     = tick ? idx_q + 3'd1 : idx_q;
    pend_d    = pend_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    seg_d     = SEG_BLANK;
    sel_d     = 8'hFF;
    wrap_d    = wrap;
    // Delayed once more so the pulse lines up with the first digit-0 output.
    fdone_d   = wrap_q;

    if (xfer) begin
      shadow_d = upd_data;
      pend_d   = 1'b1;
    end
    if (commit) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end

    case (state_q)
      SD_IDLE: begin
        if (commit) state_d = SD_SCAN;
      end
      SD_SCAN: begin
        sel_d = ~(8'b1 << idx_q);
        seg_d = lz_blank ? SEG_BLANK : dec_seg;
      end
      default: state_d = SD_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= SD_IDLE;
      div_cnt_q <= 16'd0;
      idx_q     <= 3'd0;
      pend_q    <= 1'b0;
      shadow_q  <= 32'd0;
      disp_q    <= 32'd0;
      seg_q     <= SEG_BLANK;
      sel_q     <= 8'hFF;
      wrap_q    <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      wrap_q    <= wrap_d;
      fdone_q   <= fdone_d;
    end
  end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Self-checking bench for seg_disp_ctrl against a time-based reference model.
module tb_seg_disp_ctrl;

  localparam int DIV   = 4;
  localparam int DIV2  = 2;
  localparam int FRAME = 8 * DIV;
`ifdef SEG_LZ_BLANK_EN
  localparam logic [7:0] HI_ZERO = 8'hFF;
`else
  localparam logic [7:0] HI_ZERO = 8'hC0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_data = 32'd0;
  logic        upd_ready;
  logic [7:0]  o_seg, o_sel;
  logic        frame_done, dbg_scan;

  logic        upd_valid2 = 1'b1;
  logic [31:0] upd_data2 = 32'h89AB_CDEF;
  logic        upd_ready2;
  logic [7:0]  o_seg2, o_sel2;
  logic        frame_done2, dbg_scan2;

  always #5 clk_in = ~clk_in;

  seg_disp_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk_in(clk_in), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .o_seg(o_seg), .o_sel(o_sel), .frame_done(frame_done),
    .dbg_scan_o(dbg_scan)
  );

  seg_disp_ctrl #(.SCAN_DIV(DIV2)) dut2 (
    .clk_in(clk_in), .reset(reset), .upd_valid(upd_valid2), .upd_ready(upd_ready2),
    .upd_data(upd_data2), .o_seg(o_seg2), .o_sel(o_sel2), .frame_done(frame_done2),
    .dbg_scan_o(dbg_scan2)
  );

  // ---------------- reference model ----------------
  // Time since reset release decides slot and frame boundaries arithmetically.
  logic [7:0]  hex_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  int          m_t;
  logic        m_pend, m_scan;
  logic [31:0] m_shadow, m_disp;
  logic [7:0]  e_seg, e_sel;
  logic        e_fd;

  function automatic logic [7:0] digit_pat(input logic [31:0] w, input int k);
    logic [31:0] upper;
    upper = w >> (4 * k);
`ifdef SEG_LZ_BLANK_EN
    if (k > 0 && upper == 32'd0) return 8'hFF;
`endif
    return hex_tab[upper[3:0]];
  endfunction

  always @(posedge clk_in) begin
    int slot;
    bit take, boundary;
    if (reset) begin
      m_t = 0; m_pend = 0; m_scan = 0; m_disp = 0; m_shadow = 0;
      e_seg = 8'hFF; e_sel = 8'hFF; e_fd = 0;
    end else begin
      slot = (m_t / DIV) % 8;
      if (m_scan) begin
        e_sel = ~(8'b1 << slot);
        e_seg = digit_pat(m_disp, slot);
      end else begin
        e_sel = 8'hFF;
        e_seg = 8'hFF;
      end
      e_fd     = (m_t > 0) && (m_t % FRAME == 0);
      boundary = ((m_t + 1) % FRAME == 0);
      take     = upd_valid && !m_pend;
      if (boundary && m_pend) begin
        m_disp = m_shadow; m_pend = 0; m_scan = 1;
      end else if (take) begin
        m_shadow = upd_data; m_pend = 1;
      end
      m_t++;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".seg"},   {24'd0, o_seg},    {24'd0, e_seg});
    chk({tag, ".sel"},   {24'd0, o_sel},    {24'd0, e_sel});
    chk({tag, ".fdone"}, {31'd0, frame_done}, {31'd0, e_fd});
    chk({tag, ".ready"}, {31'd0, upd_ready},  {31'd0, ~m_pend});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input string tag);
    @(posedge clk_in);
    @(negedge clk_in);
    check_all(tag);
  endtask

  task automatic load_and_show(input logic [31:0] w, input logic [7:0] d0,
                               input logic [7:0] d1, input logic [7:0] d2);
    upd_valid = 0;
    for (int i = 0; i < FRAME + 4 && m_pend; i++) cyc("lz_drain");
    upd_valid = 1; upd_data = w;
    cyc("lz_load");
    upd_valid = 0;
    for (int i = 0; i < FRAME + 4 && m_pend; i++) cyc("lz_wait");
    chk("lz_commit", {31'd0, upd_ready}, 32'd1);
    cyc("lz_d0");
    chk("lz_d0_seg", {24'd0, o_seg}, {24'd0, d0});
    repeat (DIV) cyc("lz_d1");
    chk("lz_d1_seg", {24'd0, o_seg}, {24'd0, d1});
    repeat (DIV) cyc("lz_d2");
    chk("lz_d2_seg", {24'd0, o_seg}, {24'd0, d2});
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int last_chg, last_fd;
    logic [7:0] prev_sel;

    reset = 1;
    @(negedge clk_in);
    @(negedge clk_in);
    check_all("reset");
    chk("rst_seg",   {24'd0, o_seg}, 32'hFF);
    chk("rst_sel",   {24'd0, o_sel}, 32'hFF);
    chk("rst_ready", {31'd0, upd_ready}, 32'd1);
    chk("rst_fdone", {31'd0, frame_done}, 32'd0);

    // Load on the first edge after release, then back-pressure with all-F.
    reset = 0;
    upd_valid = 1; upd_data = 32'h0123_4567;
    cyc("load");
    chk("load_ready_low", {31'd0, upd_ready}, 32'd0);
    upd_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 3 * FRAME + 2; i++) begin
      bit will_take;
      will_take = upd_valid && !m_pend;
      cyc("frame");
      if (will_take) upd_valid = 0;
      if (m_t == FRAME - 1) chk("idle_sel", {24'd0, o_sel}, 32'hFF);
      if (m_t == FRAME)     chk("commit_ready", {31'd0, upd_ready}, 32'd1);
      if (m_t == FRAME + 1) begin
        chk("f1_fdone", {31'd0, frame_done}, 32'd1);
        chk("f1_d0_sel", {24'd0, o_sel}, 32'hFE);
        chk("f1_d0_seg", {24'd0, o_seg}, 32'hF8);
        chk("bp_accept", {31'd0, upd_ready}, 32'd0);
      end
      if (m_t == FRAME + 1 + DIV) begin
        chk("f1_d1_sel", {24'd0, o_sel}, 32'hFD);
        chk("f1_d1_seg", {24'd0, o_seg}, 32'h82);
      end
      if (m_t == FRAME + 1 + 7 * DIV) begin
        chk("f1_d7_sel", {24'd0, o_sel}, 32'h7F);
        chk("f1_d7_seg", {24'd0, o_seg}, 32'hC0);
      end
      if (m_t == 2 * FRAME + 1) chk("f2_d0_seg", {24'd0, o_seg}, 32'h8E);
    end

    // Pending word, then reset at digit 5: the word must never appear.
    upd_valid = 1; upd_data = $urandom | 32'h1;
    cyc("mid_load");
    upd_valid = 0;
    for (int i = 0; i < 40; i++) begin
      if (((m_t / DIV) % 8) == 5) break;
      cyc("mid_wait");
    end
    chk("mid_pend", {31'd0, upd_ready}, 32'd0);
    reset = 1;
    cyc("mid_reset");
    chk("mid_rst_seg",   {24'd0, o_seg}, 32'hFF);
    chk("mid_rst_sel",   {24'd0, o_sel}, 32'hFF);
    chk("mid_rst_ready", {31'd0, upd_ready}, 32'd1);
    reset = 0;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      cyc("post_reset");
      chk("post_reset_sel", {24'd0, o_sel}, 32'hFF);
    end

    // Randomized traffic; small words exercise the high-zero digits.
    for (int i = 0; i < 400; i++) begin
      upd_valid = 1'($urandom_range(0, 1));
      upd_data  = ($urandom_range(0, 3) == 0) ? {24'd0, 8'($urandom)} : $urandom;
      cyc("random");
    end

    load_and_show(32'h0000_00A5, 8'h92, 8'h88, HI_ZERO);
    load_and_show(32'h0000_0000, 8'hC0, HI_ZERO, HI_ZERO);

    // Second instance: digit period and frame period at the minimum divider.
    last_chg = -1;
    last_fd  = -1;
    prev_sel = o_sel2;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (o_sel2 !== prev_sel) begin
        if (last_chg >= 0 && prev_sel != 8'hFF) chk("div2_gap", c - last_chg, DIV2);
        last_chg = c;
        prev_sel = o_sel2;
      end
      if (frame_done2) begin
        if (last_fd >= 0) chk("div2_fperiod", c - last_fd, 8 * DIV2);
        last_fd = c;
      end
    end
    chk("div2_scanning", {31'd0, dbg_scan2}, 32'd1);
    chk("div2_fd_seen", {31'd0, (last_fd >= 0)}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
